// File: rtl/mmio_mem_map.sv
// Dual-port address decoder: splits ports A/B between an MMIO register file
// and an external SRAM, exposes all registers in parallel, and lets
// accelerator done pulses clear software-set command flags.
module mmio_mem_map #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned NUM_REGS        = 14,
    parameter int unsigned REG_STRIDE_LOG2 = 8,
    parameter int unsigned MMIO_LIMIT      = 32'h1000,
    parameter int unsigned FLAG_BASE       = 10,
    parameter int unsigned NUM_FLAGS       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          data_a,
    input  logic [DATA_WIDTH-1:0]          data_b,
    input  logic [ADDR_WIDTH-1:0]          addr_a,
    input  logic [ADDR_WIDTH-1:0]          addr_b,
    input  logic                           we_a,
    input  logic                           we_b,
    output logic [DATA_WIDTH-1:0]          q_a,
    output logic [DATA_WIDTH-1:0]          q_b,
    output logic                           err_a,
    output logic                           err_b,
    output logic                           ram_we_a,
    output logic                           ram_we_b,
    input  logic [DATA_WIDTH-1:0]          ram_q_a,
    input  logic [DATA_WIDTH-1:0]          ram_q_b,
    input  logic [NUM_FLAGS-1:0]           flag_clr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic [NUM_FLAGS-1:0]           busy
);

    typedef enum logic [1:0] {
        SEL_REG  = 2'd0,
        SEL_SRAM = 2'd1,
        SEL_ERR  = 2'd2
    } sel_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [DATA_WIDTH-1:0] reg_rd_a_q, reg_rd_a_d;
    logic [DATA_WIDTH-1:0] reg_rd_b_q, reg_rd_b_d;
    sel_e                  sel_a_q, sel_a_d;
    sel_e                  sel_b_q, sel_b_d;

    logic                  sram_a, sram_b;
    logic                  valid_a, valid_b;
    logic [ADDR_WIDTH-1:0] idx_a, idx_b;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    // Same-cycle address decode: SRAM region, valid register, or unmapped MMIO
    always_comb begin
        idx_a   = addr_a >> REG_STRIDE_LOG2;
        idx_b   = addr_b >> REG_STRIDE_LOG2;
        sram_a  = addr_a >= ADDR_WIDTH'(MMIO_LIMIT);
        sram_b  = addr_b >= ADDR_WIDTH'(MMIO_LIMIT);
        valid_a = !sram_a && (addr_a[REG_STRIDE_LOG2-1:0] == '0)
                  && (idx_a < ADDR_WIDTH'(NUM_REGS));
        valid_b = !sram_b && (addr_b[REG_STRIDE_LOG2-1:0] == '0)
                  && (idx_b < ADDR_WIDTH'(NUM_REGS));
        ram_we_a = we_a && sram_a;
        ram_we_b = we_b && sram_b;
    end

    // Register read mux; index compared in full width so no out-of-range select
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (idx_a == ADDR_WIDTH'(i)) rd_a = regs_q[i];
            if (idx_b == ADDR_WIDTH'(i)) rd_b = regs_q[i];
        end
        reg_rd_a_d = valid_a ? rd_a : '0;
        reg_rd_b_d = valid_b ? rd_b : '0;
        sel_a_d    = sram_a ? SEL_SRAM : (valid_a ? SEL_REG : SEL_ERR);
        sel_b_d    = sram_b ? SEL_SRAM : (valid_b ? SEL_REG : SEL_ERR);
    end

    // Register next state: flag clear lowest priority, then port B, then port A
    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int f = 0; f < int'(NUM_FLAGS); f++) begin
            if (flag_clr[f]) regs_d[FLAG_BASE+f] = '0;
        end
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (we_b && valid_b && (idx_b == ADDR_WIDTH'(i))) regs_d[i] = data_b;
            if (we_a && valid_a && (idx_a == ADDR_WIDTH'(i))) regs_d[i] = data_a;
        end
    end

    // State registers: register file and per-port read-select pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            reg_rd_a_q <= '0;
            reg_rd_b_q <= '0;
            sel_a_q    <= SEL_REG;
            sel_b_q    <= SEL_REG;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
            reg_rd_a_q <= reg_rd_a_d;
            reg_rd_b_q <= reg_rd_b_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
        end
    end

    // Parallel register view and per-flag busy indication
    always_comb begin
        regs_flat = '0;
        busy      = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
        for (int f = 0; f < int'(NUM_FLAGS); f++) begin
            busy[f] = |regs_q[FLAG_BASE+f];
        end
    end

    // Read data steering; unmapped accesses return zero with err raised
    assign q_a   = (sel_a_q == SEL_SRAM) ? ram_q_a : reg_rd_a_q;
    assign q_b   = (sel_b_q == SEL_SRAM) ? ram_q_b : reg_rd_b_q;
    assign err_a = (sel_a_q == SEL_ERR);
    assign err_b = (sel_b_q == SEL_ERR);

endmodule
